// File: rtl/mat_trans_seq.sv
// Element-serial matrix transpose sequencer: loads N*N elements row-major, transposes, streams out.
// Optional abort input enabled by defining MAT_TRANS_SEQ_ABORT_EN.
module mat_trans_seq #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BIN_POS     = 8,
  parameter int unsigned MATRIX_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MAT_TRANS_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NumEl = MATRIX_SIZE * MATRIX_SIZE;
  localparam int unsigned CntW  = $clog2(NumEl);
  localparam int unsigned BufW  = NumEl * DATA_WIDTH;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumEl - 1);

  // Fixed-point data passes through untouched, so BIN_POS only needs to be sane.
  if (MATRIX_SIZE < 2 || BIN_POS >= DATA_WIDTH) begin : g_param_check
    $error("mat_trans_seq: invalid parameters");
  end

  typedef enum logic [1:0] {StLoad, StXfer, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [BufW-1:0] in_buf_q, in_buf_d;
  logic [BufW-1:0] res_q, res_d;
  logic            done_q, done_d;
  logic            abort_w;
  int unsigned     in_idx, out_idx;

`ifdef MAT_TRANS_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign in_idx  = {{(32 - CntW){1'b0}}, in_cnt_q};
  assign out_idx = {{(32 - CntW){1'b0}}, out_cnt_q};

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_buf_d  = in_buf_q;
    res_d     = res_q;
    done_d    = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          in_buf_d[in_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (in_cnt_q == LastIdx) begin
            in_cnt_d = '0;
            state_d  = StXfer;
          end else begin
            in_cnt_d = in_cnt_q + CntW'(1);
          end
        end
      end
      StXfer: begin
        for (int unsigned r = 0; r < MATRIX_SIZE; r++) begin
          for (int unsigned c = 0; c < MATRIX_SIZE; c++) begin
            res_d[(r*MATRIX_SIZE + c)*DATA_WIDTH +: DATA_WIDTH] =
                in_buf_q[(c*MATRIX_SIZE + r)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        state_d = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          if (out_cnt_q == LastIdx) begin
            out_cnt_d = '0;
            state_d   = StLoad;
            done_d    = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase

    // Abort wins over any handshake in the same cycle; the element in flight is dropped.
    if (abort_w) begin
      state_d   = StLoad;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      in_buf_d  = in_buf_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_buf_q  <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_buf_q  <= in_buf_d;
      res_q     <= res_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StDrain);
    out_last  = (state_q == StDrain) && (out_cnt_q == LastIdx);
    out_data  = (state_q == StDrain) ? res_q[out_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    busy      = (state_q != StLoad);
    done      = done_q;
  end

endmodule

// File: doc/mat_trans_seq.md
Name: mat_trans_seq

Overview:
- Element-serial sequencer around the fixed-point matrix transpose datapath.
- Accepts a MATRIX_SIZE x MATRIX_SIZE matrix one element per handshake in row-major order and packs it into the standard flat matrix vector (element i at bits [i*DATA_WIDTH +: DATA_WIDTH]).
- Latches the transposed matrix and streams it out row-major over a valid/ready port.
- Sits between serial producers (sensor/pose front-end) and consumers of transposed matrices in the navigation pipeline.

Parameters:
DATA_WIDTH, 16, element width in bits, signed fixed point
BIN_POS, 8, binary point position; forwarded to the transpose datapath; data bits pass unmodified
MATRIX_SIZE, 3, matrix dimension N; N >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input element valid
in_ready  out  1  sequencer can accept an input element
in_data  in  DATA_WIDTH  input element, row-major order
out_valid  out  1  output element valid
out_ready  in  1  consumer accepts output element
out_data  out  DATA_WIDTH  transposed element, row-major order
out_last  out  1  high with the final (N*N-1) output element
busy  out  1  high in XFER or DRAIN
done  out  1  one-cycle pulse after the final output handshake

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Handshake: a transfer occurs on a rising edge when valid and ready are both high. out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
- States: LOAD, XFER, DRAIN. Reset state is LOAD.
- Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, done=0, out_data=0, counters=0, matrix buffers=0.
- LOAD:
  - in_ready=1.
  - Each accepted element k (0..N*N-1) is written to slot k of the input buffer and increments in_cnt.
  - On acceptance of element N*N-1, go to XFER and clear in_cnt.
- XFER:
  - Lasts exactly one cycle. in_ready=0.
  - The result buffer registers the transpose of the input buffer: result slot r*N+c = input slot c*N+r.
  - Next state is DRAIN.
- DRAIN:
  - out_valid=1. out_data = result slot out_cnt. out_last = (out_cnt == N*N-1).
  - Each handshake increments out_cnt.
  - On the handshake with out_last=1: go to LOAD, clear out_cnt, and assert done for the next cycle only.
  - in_ready=0 throughout; there is no overlap of load and drain.
- Latency: last input accepted at edge t -> XFER during cycle t..t+1 -> out_valid=1 after edge t+1. First output is available 2 cycles after the last input handshake.
- Throughput: one element per cycle each direction when unstalled. A full matrix takes 2*N*N+1 cycles.
- Counters are clog2(N*N) bits wide and never wrap past N*N-1.
- Diagonal elements stay in place.
- Reset mid-operation: rst in any state returns to LOAD within one edge and discards all partial data.
- in_valid in XFER or DRAIN is ignored; no element is consumed.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: MAT_TRANS_SEQ_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit).
  - abort=1 at an edge in any state forces LOAD, clears counters and drops out_valid. done is not pulsed.
  - abort has priority over a simultaneous handshake: that element is discarded.
  - rst has priority over abort.
- When undefined: no `abort` port; behaviour is as above.

Test Plan:
- N=2, W=8, BIN_POS=4. Feed 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> out_data sequence 0x11, 0x33, 0x22, 0x44. out_last only on 0x44. done pulses 1 cycle after. First out_valid 2 cycles after 0x44 is accepted.
- N=3, W=16. Feed elements 0..8 -> outputs 0, 3, 6, 1, 4, 7, 2, 5, 8. in_ready=0 from XFER until the cycle after the final output.
- Backpressure: N=2, out_ready toggles 1,0,0,1,... -> out_data stable during stalls, no element lost or duplicated, order 0x11, 0x33, 0x22, 0x44.
- in_valid bubbles: random gaps while loading -> result identical to the gap-free run. Elements presented during DRAIN are not consumed.
- rst=1 after 2 of 4 inputs -> next 4 inputs 0xA1, 0xA2, 0xA3, 0xA4 give 0xA1, 0xA3, 0xA2, 0xA4 with no stale data. rst during DRAIN -> out_valid=0 next cycle.
- Signed fixed point, N=3: random $random%10 <<< BIN_POS values, 20 matrices back-to-back -> every output equals the scoreboard transpose. With MAT_TRANS_SEQ_ABORT_EN, abort mid-DRAIN -> out_valid=0 next cycle, no done pulse, next matrix correct.
